// File: rtl/reg_select_pkg.sv
// Shared types, field geometry, opcode table and slot helpers for the register-select sequencer.
// The SKIP_R0_READ_EN option is applied in reg_select_sequencer; the helpers here are option-independent.
package reg_select_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BR   = 5'd19;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd22;

  typedef enum logic [1:0] {
    CLASS_R0 = 2'd0,
    CLASS_R1 = 2'd1,
    CLASS_R2 = 2'd2,
    CLASS_R3 = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    ROLE_RA   = 2'b00,
    ROLE_RB   = 2'b01,
    ROLE_RC   = 2'b10,
    ROLE_NONE = 2'b11
  } role_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } seq_state_e;

  // Emission slots in output order; the emit mask uses the same bit positions.
  localparam logic [1:0] SLOT_RB   = 2'd0;
  localparam logic [1:0] SLOT_RC   = 2'd1;
  localparam logic [1:0] SLOT_RA   = 2'd2;
  localparam logic [1:0] SLOT_NONE = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
  } reg_fields_t;

  function automatic op_class_e opclass(input logic [OP_W-1:0] op);
    if (op <= OP_ST)        opclass = CLASS_R2;
    else if (op <= OP_ROL)  opclass = CLASS_R3;
    else if (op <= OP_NOT)  opclass = CLASS_R2;
    else if (op <= OP_MFHI) opclass = CLASS_R1;
    else                    opclass = CLASS_R0;
  endfunction

  function automatic logic [2:0] class_mask(input op_class_e cls);
    case (cls)
      CLASS_R3: class_mask = 3'b111;
      CLASS_R2: class_mask = 3'b101;
      CLASS_R1: class_mask = 3'b100;
      default:  class_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] slots_after(input logic [1:0] slot);
    case (slot)
      SLOT_RB: slots_after = 3'b110;
      SLOT_RC: slots_after = 3'b100;
      default: slots_after = 3'b000;
    endcase
  endfunction

  // Lowest set slot of mask restricted to the eligible set, SLOT_NONE if empty.
  function automatic logic [1:0] next_slot(input logic [2:0] mask, input logic [2:0] eligible);
    next_slot = SLOT_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && eligible[i]) next_slot = 2'(i);
    end
  endfunction

  function automatic role_e slot_role(input logic [1:0] slot);
    case (slot)
      SLOT_RB: slot_role = ROLE_RB;
      SLOT_RC: slot_role = ROLE_RC;
      SLOT_RA: slot_role = ROLE_RA;
      default: slot_role = ROLE_NONE;
    endcase
  endfunction

  function automatic logic [REG_W-1:0] slot_idx(input logic [1:0] slot, input reg_fields_t f);
    case (slot)
      SLOT_RB: slot_idx = f.rb;
      SLOT_RC: slot_idx = f.rc;
      default: slot_idx = f.ra;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_sequencer_if.sv
// Instruction-in / register-index-out handshake bundle for the register-select sequencer.
interface reg_select_sequencer_if;

  logic [reg_select_pkg::IR_W-1:0]  ir_in;
  logic                             ir_valid;
  logic                             ir_ready;
  logic [reg_select_pkg::REG_W-1:0] sel_idx;
  logic [1:0]                       sel_role;
  logic                             sel_valid;
  logic                             sel_last;
  logic                             sel_ready;

  modport master (
    output ir_in, ir_valid, sel_ready,
    input  ir_ready, sel_idx, sel_role, sel_valid, sel_last
  );

  modport slave (
    input  ir_in, ir_valid, sel_ready,
    output ir_ready, sel_idx, sel_role, sel_valid, sel_last
  );

endinterface

// File: rtl/reg_field_extract.sv
// Combinational split of an instruction word into opcode, register fields and opcode class.
module reg_field_extract
  import reg_select_pkg::*;
(
  input  logic [IR_W-1:0] ir_i,
  output logic [OP_W-1:0] op_o,
  output reg_fields_t     fields_o,
  output op_class_e       class_o
);

  logic unused_low_bits;

  always_comb begin
    op_o        = ir_i[OP_LSB +: OP_W];
    fields_o.ra = ir_i[RA_LSB +: REG_W];
    fields_o.rb = ir_i[RB_LSB +: REG_W];
    fields_o.rc = ir_i[RC_LSB +: REG_W];
    class_o     = opclass(op_o);
  end

  assign unused_low_bits = ^ir_i[RC_LSB-1:0];

endmodule

// File: rtl/reg_select_sequencer.sv
// Accepts an instruction, then emits its Rb/Rc/Ra register indices one per handshake.
// Option SKIP_R0_READ_EN: read operands (Rb, Rc) equal to register 0 are not emitted.
module reg_select_sequencer
  import reg_select_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  reg_select_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  reg_fields_t      fields_q, fields_d;
  logic [2:0]       mask_q, mask_d;
  logic [1:0]       step_q, step_d;
  logic             sel_valid_q, sel_valid_d;
  logic [REG_W-1:0] sel_idx_q, sel_idx_d;
  role_e            sel_role_q, sel_role_d;
  logic             sel_last_q, sel_last_d;
  logic             ir_ready_q, ir_ready_d;

  logic [OP_W-1:0]  unused_op;
  reg_fields_t      ext_fields;
  op_class_e        ext_class;
  logic [2:0]       acc_mask;
  logic [1:0]       acc_slot;
  logic [1:0]       nxt_slot;

  reg_field_extract u_extract (
    .ir_i     (bus.ir_in),
    .op_o     (unused_op),
    .fields_o (ext_fields),
    .class_o  (ext_class)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fields_q    <= '0;
      mask_q      <= '0;
      step_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      sel_role_q  <= ROLE_RA;
      sel_last_q  <= 1'b0;
      ir_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      mask_q      <= mask_d;
      step_q      <= step_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      sel_role_q  <= sel_role_d;
      sel_last_q  <= sel_last_d;
      ir_ready_q  <= ir_ready_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    fields_d    = fields_q;
    mask_d      = mask_q;
    step_d      = step_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    sel_role_d  = sel_role_q;
    sel_last_d  = sel_last_q;
    ir_ready_d  = ir_ready_q;

`ifdef SKIP_R0_READ_EN
    acc_mask = class_mask(ext_class) & ~{1'b0, ext_fields.rc == '0, ext_fields.rb == '0};
`else
    acc_mask = class_mask(ext_class);
`endif
    acc_slot = next_slot(acc_mask, 3'b111);
    nxt_slot = next_slot(mask_q, slots_after(step_q));

    case (state_q)
      ST_IDLE: begin
        // Class R0 accepts leave the sequencer idle and ready.
        if (bus.ir_valid && ir_ready_q) begin
          fields_d = ext_fields;
          if (acc_mask != 3'b000) begin
            state_d     = ST_EMIT;
            mask_d      = acc_mask;
            step_d      = acc_slot;
            sel_valid_d = 1'b1;
            sel_idx_d   = slot_idx(acc_slot, ext_fields);
            sel_role_d  = slot_role(acc_slot);
            sel_last_d  = (acc_mask & slots_after(acc_slot)) == 3'b000;
            ir_ready_d  = 1'b0;
          end
        end
      end
      ST_EMIT: begin
        if (sel_valid_q && bus.sel_ready) begin
          if (nxt_slot == SLOT_NONE) begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
            sel_last_d  = 1'b0;
            ir_ready_d  = 1'b1;
          end else begin
            step_d      = nxt_slot;
            sel_valid_d = 1'b1;
            sel_idx_d   = slot_idx(nxt_slot, fields_q);
            sel_role_d  = slot_role(nxt_slot);
            sel_last_d  = (mask_q & slots_after(nxt_slot)) == 3'b000;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ir_ready  = ir_ready_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_idx   = sel_idx_q;
  assign bus.sel_role  = sel_role_q;
  assign bus.sel_last  = sel_last_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Randomized and directed bench for reg_select_sequencer against a queue-based transfer model.
module tb_reg_select_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reg_select_sequencer_if bus();

  reg_select_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Expected pending transfers, each {last, role[1:0], idx[3:0]}.
  logic [6:0] exp_q[$];
  logic [3:0] seen[$];
  bit         live = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    mk = {op, ra, rb, rc, 15'($urandom)};
  endfunction

  // Operand list derived directly from the opcode table and emission order rules.
  task automatic push_expected(input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [5:0] list[$];
    int         n_ops;
    bit         skip_zero;
    op = ir[31:27];
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    skip_zero = 1'b0;
`ifdef SKIP_R0_READ_EN
    skip_zero = 1'b1;
`endif
    if (op <= 2 || (op >= 12 && op <= 18)) n_ops = 2;
    else if (op <= 11)                     n_ops = 3;
    else if (op <= 22)                     n_ops = 1;
    else                                   n_ops = 0;
    if (n_ops >= 2 && !(skip_zero && rb == 4'd0)) list.push_back({2'b01, rb});
    if (n_ops == 3 && !(skip_zero && rc == 4'd0)) list.push_back({2'b10, rc});
    if (n_ops >= 1) list.push_back({2'b00, ra});
    for (int i = 0; i < list.size(); i++) exp_q.push_back({i == list.size() - 1, list[i]});
  endtask

  task automatic tick();
    if (!reset && bus.sel_valid && bus.sel_ready) seen.push_back(bus.sel_idx);
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      live = 1'b1;
    end else if (live) begin
      if (exp_q.size() != 0 && bus.sel_ready) void'(exp_q.pop_front());
      else if (exp_q.size() == 0 && bus.ir_valid) push_expected(bus.ir_in);
    end
    @(negedge clock);
    if (live) begin
      check("sel_valid", 32'(bus.sel_valid), 32'(exp_q.size() != 0));
      check("ir_ready", 32'(bus.ir_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() != 0) begin
        check("sel_idx", 32'(bus.sel_idx), 32'(exp_q[0][3:0]));
        check("sel_role", 32'(bus.sel_role), 32'(exp_q[0][5:4]));
        check("sel_last", 32'(bus.sel_last), 32'(exp_q[0][6]));
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ir, input bit rdy);
    bus.ir_valid  = v;
    bus.ir_in     = ir;
    bus.sel_ready = rdy;
    tick();
  endtask

  task automatic check_seen(input string tag, input int n, input logic [3:0] e0,
                            input logic [3:0] e1, input logic [3:0] e2);
    logic [3:0] e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    check({tag, "_count"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n && i < seen.size(); i++) check({tag, "_idx"}, 32'(seen[i]), 32'(e[i]));
    seen.delete();
  endtask

  initial begin
    bus.ir_valid  = 1'b0;
    bus.ir_in     = '0;
    bus.sel_ready = 1'b0;
    reset = 1'b1;
    drive(0, 32'h0, 0);
    drive(0, 32'h0, 0);
    reset = 1'b0;
    check("reset_idx", 32'(bus.sel_idx), 32'h0);
    seen.delete();

    // add r3,r5,r7 with downstream always ready
    drive(1, mk(5'd3, 4'd3, 4'd5, 4'd7), 1);
    repeat (4) drive(0, mk(5'd4, 4'd1, 4'd1, 4'd1), 1);
    check_seen("t1", 3, 4'd5, 4'd7, 4'd3);

    // addi r2,r4 with first index stalled
    drive(1, mk(5'd12, 4'd2, 4'd4, 4'd0), 0);
    repeat (3) drive(0, 32'h0, 0);
    repeat (3) drive(0, 32'h0, 1);
    check_seen("t2", 2, 4'd4, 4'd2, 4'd0);

    // unmapped opcode then single-operand branch
    drive(1, mk(5'd25, 4'd1, 4'd2, 4'd3), 1);
    drive(1, mk(5'd19, 4'd9, 4'd2, 4'd3), 1);
    repeat (3) drive(0, 32'h0, 1);
    check_seen("t3", 1, 4'd9, 4'd0, 4'd0);

    // reset while the second index of an R3 is presented
    drive(1, mk(5'd4, 4'd1, 4'd2, 4'd3), 1);
    drive(0, 32'h0, 1);
    reset = 1'b1;
    drive(0, 32'h0, 1);
    reset = 1'b0;
    seen.delete();
    repeat (3) drive(0, 32'h0, 1);
    check_seen("t4", 0, 4'd0, 4'd0, 4'd0);

    // add r6,r0,r0
    drive(1, mk(5'd3, 4'd6, 4'd0, 4'd0), 1);
    repeat (4) drive(0, 32'h0, 1);
`ifdef SKIP_R0_READ_EN
    check_seen("t5", 1, 4'd6, 4'd0, 4'd0);
`else
    check_seen("t5", 3, 4'd0, 4'd0, 4'd6);
`endif

    // ir_valid held high across back-to-back instructions
    for (int i = 0; i < 12; i++) drive(1, mk(5'($urandom_range(22)), 4'($urandom), 4'($urandom), 4'($urandom)), 1);
    drive(0, 32'h0, 1);
    repeat (4) drive(0, 32'h0, 1);

    // random traffic with stalls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) == 0);
      drive(1'($urandom), mk(5'($urandom), 4'($urandom), 4'($urandom_range(3)), 4'($urandom_range(3))),
            $urandom_range(9) < 7);
    end
    reset = 1'b0;
    repeat (6) drive(0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
